// File: rtl/writeback_tracker.sv
// Destination-register pipeline (EX/MEM/WB) with load-use hazard detection,
// an in-flight write bitmap and a saturating count of load-use stall cycles.
module writeback_tracker #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       valid_id_i,
  input  logic                       reg_write_id_i,
  input  logic                       mem_read_id_i,
  input  logic [REG_ADDR_W-1:0]      rd_id_i,
  input  logic [REG_ADDR_W-1:0]      rs1_id_i,
  input  logic [REG_ADDR_W-1:0]      rs2_id_i,
  input  logic                       use_rs1_id_i,
  input  logic                       use_rs2_id_i,
  input  logic                       flush_i,
  input  logic                       mem_stall_i,
  output logic                       reg_write_ex_o,
  output logic [REG_ADDR_W-1:0]      rd_ex_o,
  output logic                       mem_read_ex_o,
  output logic                       reg_write_mem_o,
  output logic [REG_ADDR_W-1:0]      rd_mem_o,
  output logic                       reg_write_wb_o,
  output logic [REG_ADDR_W-1:0]      rd_wb_o,
  output logic                       stall_id_o,
  output logic [2**REG_ADDR_W-1:0]   pending_o,
  output logic [CNT_W-1:0]           stall_count_o
);

  localparam int NREGS = 2**REG_ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic                  rw_ex_q, rw_ex_d;
  logic                  mr_ex_q, mr_ex_d;
  logic [REG_ADDR_W-1:0] rd_ex_q, rd_ex_d;
  logic                  rw_mem_q, rw_mem_d;
  logic [REG_ADDR_W-1:0] rd_mem_q, rd_mem_d;
  logic                  rw_wb_q, rw_wb_d;
  logic [REG_ADDR_W-1:0] rd_wb_q, rd_wb_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  rd_nonzero;
  logic                  cap_rw;
  logic                  cap_mr;
  logic                  rs1_hit;
  logic                  rs2_hit;
  logic                  stall;

  always_comb begin
    rd_nonzero = (rd_id_i != '0);
    cap_rw     = valid_id_i & reg_write_id_i & rd_nonzero;
    cap_mr     = valid_id_i & mem_read_id_i & rd_nonzero;
    rs1_hit    = use_rs1_id_i & (rs1_id_i == rd_ex_q);
    rs2_hit    = use_rs2_id_i & (rs2_id_i == rd_ex_q);
    stall      = valid_id_i & mr_ex_q & rw_ex_q & (rs1_hit | rs2_hit) & ~flush_i;
  end

  always_comb begin
    rw_ex_d  = rw_ex_q;
    mr_ex_d  = mr_ex_q;
    rd_ex_d  = rd_ex_q;
    rw_mem_d = rw_mem_q;
    rd_mem_d = rd_mem_q;
    rw_wb_d  = rw_wb_q;
    rd_wb_d  = rd_wb_q;
    cnt_d    = cnt_q;
    // A memory freeze holds everything, including a pending flush.
    if (!mem_stall_i) begin
      rw_wb_d  = rw_mem_q;
      rd_wb_d  = rd_mem_q;
      rw_mem_d = rw_ex_q;
      rd_mem_d = rd_ex_q;
      if (flush_i || stall) begin
        rw_ex_d = 1'b0;
        mr_ex_d = 1'b0;
        rd_ex_d = '0;
      end else begin
        rw_ex_d = cap_rw;
        mr_ex_d = cap_mr;
        rd_ex_d = rd_id_i;
      end
      if (stall && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rw_ex_q  <= 1'b0;
      mr_ex_q  <= 1'b0;
      rd_ex_q  <= '0;
      rw_mem_q <= 1'b0;
      rd_mem_q <= '0;
      rw_wb_q  <= 1'b0;
      rd_wb_q  <= '0;
      cnt_q    <= '0;
    end else begin
      rw_ex_q  <= rw_ex_d;
      mr_ex_q  <= mr_ex_d;
      rd_ex_q  <= rd_ex_d;
      rw_mem_q <= rw_mem_d;
      rd_mem_q <= rd_mem_d;
      rw_wb_q  <= rw_wb_d;
      rd_wb_q  <= rd_wb_d;
      cnt_q    <= cnt_d;
    end
  end

  // Register 0 is never written, so its pending bit is tied low.
  assign pending_o[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_pending
      assign pending_o[gi] = (rw_ex_q  && (rd_ex_q  == REG_ADDR_W'(gi))) ||
                             (rw_mem_q && (rd_mem_q == REG_ADDR_W'(gi))) ||
                             (rw_wb_q  && (rd_wb_q  == REG_ADDR_W'(gi)));
    end
  endgenerate

  assign reg_write_ex_o  = rw_ex_q;
  assign rd_ex_o         = rd_ex_q;
  assign mem_read_ex_o   = mr_ex_q;
  assign reg_write_mem_o = rw_mem_q;
  assign rd_mem_o        = rd_mem_q;
  assign reg_write_wb_o  = rw_wb_q;
  assign rd_wb_o         = rd_wb_q;
  assign stall_id_o      = stall;
  assign stall_count_o   = cnt_q;

endmodule

// File: tb/tb_writeback_tracker.sv
// Directed and random stimulus for writeback_tracker, checked every cycle
// against a queue-style pipeline model built from the behavioural rules.
module tb_writeback_tracker;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int NR = 2**AW;
  localparam int CMAX = 2**CW - 1;

  logic clk = 1'b0;
  logic rst, valid, rw_id, mr_id, u1, u2, flush, mstall;
  logic [AW-1:0] rd_id, rs1, rs2;
  logic rw_ex, mr_ex, rw_mem, rw_wb, stall_id;
  logic [AW-1:0] rd_ex, rd_mem, rd_wb;
  logic [NR-1:0] pending;
  logic [CW-1:0] scount;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    bit       rw;
    bit       mr;
    bit [4:0] rd;
  } ent_t;

  ent_t m_pipe[3];   // 0 = EX, 1 = MEM, 2 = WB
  int   m_cnt;

  always #5 clk = ~clk;

  writeback_tracker #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .valid_id_i(valid), .reg_write_id_i(rw_id),
    .mem_read_id_i(mr_id), .rd_id_i(rd_id), .rs1_id_i(rs1), .rs2_id_i(rs2),
    .use_rs1_id_i(u1), .use_rs2_id_i(u2), .flush_i(flush), .mem_stall_i(mstall),
    .reg_write_ex_o(rw_ex), .rd_ex_o(rd_ex), .mem_read_ex_o(mr_ex),
    .reg_write_mem_o(rw_mem), .rd_mem_o(rd_mem), .reg_write_wb_o(rw_wb),
    .rd_wb_o(rd_wb), .stall_id_o(stall_id), .pending_o(pending),
    .stall_count_o(scount)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_stall();
    return valid && m_pipe[0].mr && m_pipe[0].rw && !flush &&
           ((u1 && rs1 == m_pipe[0].rd) || (u2 && rs2 == m_pipe[0].rd));
  endfunction

  function automatic logic [NR-1:0] m_pending();
    logic [NR-1:0] p = '0;
    for (int s = 0; s < 3; s++)
      if (m_pipe[s].rw) p[m_pipe[s].rd] = 1'b1;
    return p;
  endfunction

  task automatic m_reset();
    for (int s = 0; s < 3; s++) m_pipe[s] = '{rw: 0, mr: 0, rd: 0};
    m_cnt = 0;
  endtask

  // Drive one ID slot, check all outputs mid-cycle, then advance the model at the edge.
  task automatic cycle(input bit v, input bit w, input bit m, input int d,
                       input int a, input int b, input bit ua, input bit ub,
                       input bit fl, input bit ms, input bit r);
    bit   st;
    ent_t cap;
    valid = v; rw_id = w; mr_id = m; rd_id = AW'(d); rs1 = AW'(a); rs2 = AW'(b);
    u1 = ua; u2 = ub; flush = fl; mstall = ms; rst = r;
    #1;
    st = m_stall();
    chk("stall_id", stall_id, st);
    chk("rw_ex", rw_ex, m_pipe[0].rw);
    chk("mr_ex", mr_ex, m_pipe[0].mr);
    chk("rd_ex", rd_ex, m_pipe[0].rd);
    chk("rw_mem", rw_mem, m_pipe[1].rw);
    chk("rd_mem", rd_mem, m_pipe[1].rd);
    chk("rw_wb", rw_wb, m_pipe[2].rw);
    chk("rd_wb", rd_wb, m_pipe[2].rd);
    chk("pending", pending, m_pending());
    chk("stall_count", scount, m_cnt);
    @(posedge clk);
    if (r) begin
      m_reset();
    end else if (!ms) begin
      cap.rw = v && w && (d != 0);
      cap.mr = v && m && (d != 0);
      cap.rd = 5'(d);
      m_pipe[2] = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = (fl || st) ? '{rw: 0, mr: 0, rd: 0} : cap;
      if (st && m_cnt < CMAX) m_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic nop();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    rst = 1; valid = 0; rw_id = 0; mr_id = 0; rd_id = 0; rs1 = 0; rs2 = 0;
    u1 = 0; u2 = 0; flush = 0; mstall = 0;
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("reset_pending", pending, 0);
    chk("reset_count", scount, 0);
    chk("reset_rw_ex", rw_ex, 0);

    // T1: lw x5 then independent add x6,x1,x2
    cycle(1, 1, 1, 5, 0, 0, 1, 0, 0, 0, 0);
    chk("t1_rd_ex", {rw_ex, rd_ex}, {1'b1, 5'd5});
    cycle(1, 1, 0, 6, 1, 2, 1, 1, 0, 0, 0);
    chk("t1_rd_mem", rd_mem, 5);
    nop();
    chk("t1_rd_wb", rd_wb, 5);
    nop(); nop();

    // T2: lw x7; add x1,x7,x2 stalls once, then enters EX
    cycle(1, 1, 1, 7, 0, 0, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 1, 7, 2, 1, 1, 0, 0, 0);
    chk("t2_ex_bubble", rw_ex, 0);
    chk("t2_count", scount, 1);
    cycle(1, 1, 0, 1, 7, 2, 1, 1, 0, 0, 0);
    chk("t2_add_in_ex", {rw_ex, rd_ex}, {1'b1, 5'd1});
    nop(); nop(); nop();

    // T3: write to x0 never becomes pending
    cycle(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t3_rw_ex", rw_ex, 0);
    nop();
    chk("t3_pending", pending, 0);
    nop(); nop();

    // T4: lw x3 then flushed dependent user
    cycle(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 8, 3, 3, 1, 1, 1, 0, 0);
    chk("t4_ex_bubble", rw_ex, 0);
    chk("t4_count", scount, 1);
    nop(); nop(); nop();

    // T5: freeze with EX=x4, MEM=x9
    do_reset();
    nop(); nop(); nop();
    cycle(1, 1, 0, 9, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 4, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 12, 4, 9, 1, 1, 1, 1, 0);
    chk("t5_pending", pending, (64'd1 << 4) | (64'd1 << 9));
    chk("t5_ex_mem", {rd_ex, rd_mem}, {5'd4, 5'd9});
    nop(); nop(); nop();

    // T6: saturate the counter, then reset mid-stall
    do_reset();
    for (int i = 0; i < CMAX + 3; i++) begin
      cycle(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 1, 0, 2, 0, 7, 0, 1, 0, 0, 0);
      cycle(1, 1, 0, 2, 0, 7, 0, 1, 0, 0, 0);
    end
    chk("t6_saturated", scount, CMAX);
    cycle(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 2, 7, 0, 1, 0, 0, 0, 1);
    chk("t6_reset_all", {rw_ex, mr_ex, rd_ex, rw_mem, rd_mem, rw_wb, rd_wb, scount},
        64'd0);
    chk("t6_reset_pending", pending, 0);

    // Random traffic over a small register range so hazards are frequent
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 4),
            $urandom_range(0, 4), $urandom_range(0, 4),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 59) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
